// File: rtl/pe_pkg.sv
// pe_pkg: shared types and helpers for the output-stationary PE.
// Holds the tile FSM state enum, the result narrowing function and width limits.
package pe_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } pe_state_e;

    // Narrowing works on a 64-bit working value; the accumulator
    // must fit with at least one bit of headroom for sign extension.
    localparam int NARROW_W  = 64;
    localparam int MAX_ACC_W = NARROW_W - 1;

    function automatic bit pe_cfg_ok(
        input int dw,
        input int aw,
        input int ow
    );
        return (aw >= 2 * dw) && (ow <= aw) && (aw <= MAX_ACC_W)
            && (dw > 0) && (ow > 0);
    endfunction

    // Clamp v into the ow-bit range when sat is set; the caller keeps
    // the low ow bits, so without sat this is plain wrap-around.
    function automatic logic [NARROW_W-1:0] pe_narrow(
        input logic [NARROW_W-1:0] v,
        input int                  ow,
        input bit                  sgn,
        input bit                  sat
    );
        logic [NARROW_W-1:0] hi;
        logic [NARROW_W-1:0] lo;
        logic [NARROW_W-1:0] r;
        hi = '0;
        lo = '0;
        r  = v;
        if (sat) begin
            if (sgn) begin
                hi = (64'd1 << (ow - 1)) - 64'd1;
                lo = ~hi;
                if ($signed(v) > $signed(hi)) begin
                    r = hi;
                end else if ($signed(v) < $signed(lo)) begin
                    r = lo;
                end
            end else begin
                hi = (64'd1 << ow) - 64'd1;
                if (v > hi) begin
                    r = hi;
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/pe_os_acc_mul.sv
// pe_mul: combinational DATA_WIDTH x DATA_WIDTH multiplier, full 2*DATA_WIDTH product.
// Ports: a, b (operands), p (product); SIGNED selects two's-complement operands.
module pe_mul #(
    parameter int DATA_WIDTH = 8,
    parameter int SIGNED     = 1
) (
    input  logic [DATA_WIDTH-1:0]   a,
    input  logic [DATA_WIDTH-1:0]   b,
    output logic [2*DATA_WIDTH-1:0] p
);

    logic [2*DATA_WIDTH-1:0] a_x;
    logic [2*DATA_WIDTH-1:0] b_x;

    // Extending both operands to the product width makes the low
    // 2*DATA_WIDTH bits of the truncated product exact in either mode.
    always_comb begin
        if (SIGNED != 0) begin
            a_x = {{DATA_WIDTH{a[DATA_WIDTH-1]}}, a};
            b_x = {{DATA_WIDTH{b[DATA_WIDTH-1]}}, b};
        end else begin
            a_x = {{DATA_WIDTH{1'b0}}, a};
            b_x = {{DATA_WIDTH{1'b0}}, b};
        end
        p = a_x * b_x;
    end

endmodule

// File: rtl/pe_os_acc.sv
// pe_os_acc: output-stationary systolic PE with valid tracking, per-tile MAC
// count, IDLE/ACCUM/DONE accumulate FSM and a column drain chain.
// Ports: clk, rst (async, active-high); start/k_len begin a tile;
//   top_in/left_in (+vld) operands, passed to bottom_out/right_out after 1 cycle;
//   drain_en selects drain_in (+vld) over own result onto drain_out (+vld);
//   busy = accumulating, done = result held.
// Build option: define PE_SAT_EN to saturate the narrowed result instead of wrapping.
module pe_os_acc
    import pe_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ACC_WIDTH  = 24,
    parameter int OUT_WIDTH  = 16,
    parameter int OUT_SHIFT  = 0,
    parameter int CNT_WIDTH  = 10,
    parameter int SIGNED     = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [CNT_WIDTH-1:0]  k_len,
    input  logic [DATA_WIDTH-1:0] top_in,
    input  logic                  top_vld_in,
    input  logic [DATA_WIDTH-1:0] left_in,
    input  logic                  left_vld_in,
    output logic [DATA_WIDTH-1:0] bottom_out,
    output logic                  bottom_vld_out,
    output logic [DATA_WIDTH-1:0] right_out,
    output logic                  right_vld_out,
    input  logic                  drain_en,
    input  logic [OUT_WIDTH-1:0]  drain_in,
    input  logic                  drain_vld_in,
    output logic [OUT_WIDTH-1:0]  drain_out,
    output logic                  drain_vld_out,
    output logic                  busy,
    output logic                  done
);

`ifdef PE_SAT_EN
    localparam bit SAT_EN = 1'b1;
`else
    localparam bit SAT_EN = 1'b0;
`endif

    if (!pe_cfg_ok(DATA_WIDTH, ACC_WIDTH, OUT_WIDTH)) begin : g_cfg_err
        $error("pe_os_acc: illegal width configuration");
    end

    pe_state_e state_q;
    pe_state_e state_d;

    logic [ACC_WIDTH-1:0]    acc_q;
    logic [CNT_WIDTH-1:0]    cnt_q;
    logic [CNT_WIDTH-1:0]    klen_q;
    logic [2*DATA_WIDTH-1:0] prod;
    logic [ACC_WIDTH-1:0]    prod_ext;
    logic                    fire;
    logic                    last;
    logic [NARROW_W-1:0]     acc_x;
    logic [NARROW_W-1:0]     acc_sh;
    logic [OUT_WIDTH-1:0]    res;

    pe_mul #(
        .DATA_WIDTH(DATA_WIDTH),
        .SIGNED    (SIGNED)
    ) u_mul (
        .a(top_in),
        .b(left_in),
        .p(prod)
    );

    always_comb begin
        if (SIGNED != 0) begin
            prod_ext = ACC_WIDTH'($signed(prod));
        end else begin
            prod_ext = ACC_WIDTH'(prod);
        end
    end

    assign fire = (state_q == ACCUM) & top_vld_in & left_vld_in;
    assign last = fire & (cnt_q == klen_q - CNT_WIDTH'(1));

    // start wins over everything, including a same-cycle drain.
    always_comb begin
        state_d = state_q;
        if (start) begin
            state_d = (k_len == '0) ? DONE : ACCUM;
        end else begin
            unique case (state_q)
                ACCUM:   if (last) state_d = DONE;
                DONE:    if (drain_en) state_d = IDLE;
                default: state_d = state_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q  <= '0;
            cnt_q  <= '0;
            klen_q <= '0;
        end else if (start) begin
            acc_q  <= '0;
            cnt_q  <= '0;
            klen_q <= k_len;
        end else if (fire) begin
            acc_q <= acc_q + prod_ext;
            cnt_q <= cnt_q + CNT_WIDTH'(1);
        end
    end

    // Widen to the working width so the shift is arithmetic in signed mode.
    always_comb begin
        if (SIGNED != 0) begin
            acc_x  = {{(NARROW_W-ACC_WIDTH){acc_q[ACC_WIDTH-1]}}, acc_q};
            acc_sh = $signed(acc_x) >>> OUT_SHIFT;
        end else begin
            acc_x  = {{(NARROW_W-ACC_WIDTH){1'b0}}, acc_q};
            acc_sh = acc_x >> OUT_SHIFT;
        end
        res = OUT_WIDTH'(pe_narrow(acc_sh, OUT_WIDTH, SIGNED != 0, SAT_EN));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bottom_out     <= '0;
            bottom_vld_out <= 1'b0;
            right_out      <= '0;
            right_vld_out  <= 1'b0;
            drain_out      <= '0;
            drain_vld_out  <= 1'b0;
        end else begin
            bottom_out     <= top_in;
            bottom_vld_out <= top_vld_in;
            right_out      <= left_in;
            right_vld_out  <= left_vld_in;
            if (drain_en) begin
                drain_out     <= drain_in;
                drain_vld_out <= drain_vld_in;
            end else begin
                drain_out     <= res;
                drain_vld_out <= (state_q == DONE);
            end
        end
    end

    assign busy = (state_q == ACCUM);
    assign done = (state_q == DONE);

endmodule

// File: tb/tb_pe_os_acc.sv
// tb_pe_os_acc: directed + randomized bench for pe_os_acc.
// Lanes 0-3 form a drain column, lane 4 is unsigned with OUT_SHIFT=4, lane 5 is an 8-bit-out twin of lane 4.
module tb_pe_os_acc;

    localparam int DW = 8;
    localparam int AW = 24;
    localparam int OW = 16;
    localparam int CW = 10;
    localparam int NL = 5;
    localparam int NM = 6;
`ifdef PE_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic          st   [NL];
    logic [CW-1:0] kl   [NL];
    logic [DW-1:0] ti   [NL];
    logic          tv   [NL];
    logic [DW-1:0] li   [NL];
    logic          lv   [NL];
    logic          den  [NL];
    logic [OW-1:0] din  [NL];
    logic          dvin [NL];

    logic [DW-1:0] bot  [NM];
    logic          bv   [NM];
    logic [DW-1:0] rgt  [NM];
    logic          rv   [NM];
    logic [OW-1:0] dout [NM];
    logic          dv   [NM];
    logic          busy [NM];
    logic          done [NM];
    logic [7:0]    s_dout;

    assign dout[5] = {8'h00, s_dout};

    for (genvar g = 0; g < NL; g++) begin : g_lane
        if (g >= 1 && g <= 3) begin : g_chain
            assign din[g]  = dout[g-1];
            assign dvin[g] = dv[g-1];
        end else begin : g_head
            assign din[g]  = '0;
            assign dvin[g] = 1'b0;
        end
        pe_os_acc #(
            .DATA_WIDTH(DW),
            .ACC_WIDTH (AW),
            .OUT_WIDTH (OW),
            .OUT_SHIFT (g == 4 ? 4 : 0),
            .CNT_WIDTH (CW),
            .SIGNED    (g == 4 ? 0 : 1)
        ) u_pe (
            .clk           (clk),
            .rst           (rst),
            .start         (st[g]),
            .k_len         (kl[g]),
            .top_in        (ti[g]),
            .top_vld_in    (tv[g]),
            .left_in       (li[g]),
            .left_vld_in   (lv[g]),
            .bottom_out    (bot[g]),
            .bottom_vld_out(bv[g]),
            .right_out     (rgt[g]),
            .right_vld_out (rv[g]),
            .drain_en      (den[g]),
            .drain_in      (din[g]),
            .drain_vld_in  (dvin[g]),
            .drain_out     (dout[g]),
            .drain_vld_out (dv[g]),
            .busy          (busy[g]),
            .done          (done[g])
        );
    end

    pe_os_acc #(
        .DATA_WIDTH(DW),
        .ACC_WIDTH (AW),
        .OUT_WIDTH (8),
        .OUT_SHIFT (0),
        .CNT_WIDTH (CW),
        .SIGNED    (1)
    ) u_sat (
        .clk           (clk),
        .rst           (rst),
        .start         (st[4]),
        .k_len         (kl[4]),
        .top_in        (ti[4]),
        .top_vld_in    (tv[4]),
        .left_in       (li[4]),
        .left_vld_in   (lv[4]),
        .bottom_out    (bot[5]),
        .bottom_vld_out(bv[5]),
        .right_out     (rgt[5]),
        .right_vld_out (rv[5]),
        .drain_en      (den[4]),
        .drain_in      (8'h00),
        .drain_vld_in  (1'b0),
        .drain_out     (s_dout),
        .drain_vld_out (dv[5]),
        .busy          (busy[5]),
        .done          (done[5])
    );

    // Reference model: a tile is "active" from start until drained;
    // it has taken all its MACs once fired reaches k.
    bit            m_act [NM];
    int            m_fir [NM];
    int            m_k   [NM];
    longint        m_sum [NM];
    logic [OW-1:0] e_dout[NM];
    bit            e_dv  [NM];
    logic [DW-1:0] e_bot [NM];
    bit            e_bv  [NM];
    logic [DW-1:0] e_rgt [NM];
    bit            e_rv  [NM];

    int checks = 0;
    int passes = 0;

    function automatic int lane_of(int i);
        return (i == 5) ? 4 : i;
    endfunction

    function automatic bit sgn_of(int i);
        return i != 4;
    endfunction

    function automatic int ow_of(int i);
        return (i == 5) ? 8 : OW;
    endfunction

    function automatic int sh_of(int i);
        return (i == 4) ? 4 : 0;
    endfunction

    function automatic longint mul(int i, logic [DW-1:0] a, logic [DW-1:0] b);
        if (sgn_of(i)) return longint'($signed(a)) * longint'($signed(b));
        return longint'(a) * longint'(b);
    endfunction

    function automatic logic [OW-1:0] model_res(int i, longint sum);
        longint one;
        longint a;
        longint hi;
        longint lo;
        one = 1;
        a = sum & ((one << AW) - 1);
        if (sgn_of(i) && a >= (one << (AW - 1))) a = a - (one << AW);
        a = a >>> sh_of(i);
        if (SAT) begin
            if (sgn_of(i)) begin
                hi = (one << (ow_of(i) - 1)) - 1;
                lo = -hi - 1;
            end else begin
                hi = (one << ow_of(i)) - 1;
                lo = 0;
            end
            if (a > hi) a = hi;
            if (a < lo) a = lo;
        end
        a = a & ((one << ow_of(i)) - 1);
        return OW'(a);
    endfunction

    task automatic model_step();
        logic [OW-1:0] nd [NM];
        bit            nv [NM];
        int            l;
        bit            dn;
        for (int i = 0; i < NM; i++) begin
            l = lane_of(i);
            if (rst) begin
                m_act[i] = 1'b0;
                m_fir[i] = 0;
                m_k[i]   = 0;
                m_sum[i] = 0;
                nd[i]    = '0;
                nv[i]    = 1'b0;
                e_bot[i] = '0;
                e_bv[i]  = 1'b0;
                e_rgt[i] = '0;
                e_rv[i]  = 1'b0;
            end else begin
                dn = m_act[i] && (m_fir[i] >= m_k[i]);
                e_bot[i] = ti[l];
                e_bv[i]  = tv[l];
                e_rgt[i] = li[l];
                e_rv[i]  = lv[l];
                if (den[l]) begin
                    if (i >= 1 && i <= 3) begin
                        nd[i] = e_dout[i-1];
                        nv[i] = e_dv[i-1];
                    end else begin
                        nd[i] = '0;
                        nv[i] = 1'b0;
                    end
                end else begin
                    nd[i] = model_res(i, m_sum[i]);
                    nv[i] = dn;
                end
                if (st[l]) begin
                    m_act[i] = 1'b1;
                    m_fir[i] = 0;
                    m_sum[i] = 0;
                    m_k[i]   = int'(kl[l]);
                end else if (m_act[i] && m_fir[i] < m_k[i] && tv[l] && lv[l]) begin
                    m_sum[i] = m_sum[i] + mul(i, ti[l], li[l]);
                    m_fir[i] = m_fir[i] + 1;
                end else if (dn && den[l]) begin
                    m_act[i] = 1'b0;
                end
            end
        end
        for (int i = 0; i < NM; i++) begin
            e_dout[i] = nd[i];
            e_dv[i]   = nv[i];
        end
    endtask

    task automatic chk(string tag, int i, logic [63:0] obs, logic [63:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s[%0d] observed=%0h expected=%0h", tag, i, obs, exp);
    endtask

    task automatic check_all();
        for (int i = 0; i < NM; i++) begin
            chk("busy", i, busy[i], m_act[i] && m_fir[i] < m_k[i]);
            chk("done", i, done[i], m_act[i] && m_fir[i] >= m_k[i]);
            chk("drain_out", i, dout[i], e_dout[i]);
            chk("drain_vld", i, dv[i], e_dv[i]);
            chk("bottom", i, bot[i], e_bot[i]);
            chk("bottom_vld", i, bv[i], e_bv[i]);
            chk("right", i, rgt[i], e_rgt[i]);
            chk("right_vld", i, rv[i], e_rv[i]);
        end
    endtask

    task automatic cyc();
        model_step();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic quiet();
        for (int l = 0; l < NL; l++) begin
            st[l]  = 1'b0;
            tv[l]  = 1'b0;
            lv[l]  = 1'b0;
            den[l] = 1'b0;
            ti[l]  = DW'($urandom);
            li[l]  = DW'($urandom);
        end
    endtask

    task automatic mac(int l, logic [DW-1:0] a, logic [DW-1:0] b, bit va, bit vb);
        ti[l] = a;
        li[l] = b;
        tv[l] = va;
        lv[l] = vb;
        cyc();
    endtask

    logic [OW-1:0] col_exp [4];
    logic [7:0]    sat_exp;

    initial begin
        rst = 1'b1;
        for (int l = 0; l < NL; l++) kl[l] = '0;
        quiet();
        cyc();
        cyc();
        rst = 1'b0;
        cyc();
        cyc();

        // k_len=3: 2*3 - 4*5 + 7*1 = -7
        st[0] = 1'b1;
        kl[0] = CW'(3);
        cyc();
        st[0] = 1'b0;
        mac(0, 8'd2, 8'd3, 1, 1);
        mac(0, 8'hFC, 8'd5, 1, 1);
        mac(0, 8'd7, 8'd1, 1, 1);
        chk("t2_done", 0, done[0], 1'b1);
        quiet();
        cyc();
        chk("t2_res", 0, dout[0], 16'hFFF9);
        chk("t2_vld", 0, dv[0], 1'b1);

        // bubbles: only the two both-valid beats count, 12 - 18 = -6
        st[1] = 1'b1;
        kl[1] = CW'(2);
        cyc();
        st[1] = 1'b0;
        mac(1, 8'd5, 8'd6, 1, 0);
        mac(1, 8'd5, 8'd6, 0, 1);
        mac(1, 8'd3, 8'd4, 1, 1);
        mac(1, 8'd9, 8'd9, 1, 0);
        mac(1, 8'd9, 8'd9, 0, 1);
        mac(1, 8'hFE, 8'd9, 1, 1);
        mac(1, 8'd100, 8'd100, 1, 1);
        quiet();
        cyc();
        chk("t3_res", 1, dout[1], 16'hFFFA);

        // column drain of 10,20,30,40
        for (int l = 0; l < 4; l++) begin
            st[l] = 1'b1;
            kl[l] = CW'(1);
        end
        cyc();
        for (int l = 0; l < 4; l++) begin
            st[l] = 1'b0;
            ti[l] = DW'(10 * (l + 1));
            li[l] = 8'd1;
            tv[l] = 1'b1;
            lv[l] = 1'b1;
        end
        cyc();
        quiet();
        cyc();
        col_exp = '{16'd40, 16'd30, 16'd20, 16'd10};
        for (int l = 0; l < 4; l++) den[l] = 1'b1;
        for (int j = 0; j < 4; j++) begin
            chk("col_out", j, dout[3], col_exp[j]);
            chk("col_vld", j, dv[3], 1'b1);
            cyc();
        end
        quiet();
        chk("col_tail_vld", 3, dv[3], 1'b0);
        for (int l = 0; l < 4; l++) chk("col_idle", l, done[l], 1'b0);

        // 4 x 127*127 = 64516 on the unsigned and 8-bit lanes
        st[4] = 1'b1;
        kl[4] = CW'(4);
        cyc();
        st[4] = 1'b0;
        for (int j = 0; j < 4; j++) mac(4, 8'd127, 8'd127, 1, 1);
        quiet();
        cyc();
        sat_exp = SAT ? 8'd127 : 8'h04;
        chk("sat_out", 5, s_dout, sat_exp);
        chk("shift_out", 4, dout[4], 16'h0FC0);

        // restart mid-tile, then a k_len=0 tile
        st[2] = 1'b1;
        kl[2] = CW'(5);
        cyc();
        st[2] = 1'b0;
        mac(2, 8'd3, 8'd3, 1, 1);
        mac(2, 8'd3, 8'd3, 1, 1);
        st[2] = 1'b1;
        kl[2] = CW'(2);
        mac(2, 8'd1, 8'd1, 1, 1);
        st[2] = 1'b0;
        chk("t6_busy", 2, busy[2], 1'b1);
        mac(2, 8'd4, 8'd4, 1, 1);
        mac(2, 8'd5, 8'd5, 1, 1);
        quiet();
        cyc();
        chk("t6_res", 2, dout[2], 16'd41);
        st[2] = 1'b1;
        kl[2] = '0;
        cyc();
        st[2] = 1'b0;
        chk("t6_k0_done", 2, done[2], 1'b1);
        cyc();
        chk("t6_k0_res", 2, dout[2], 16'd0);
        chk("t6_k0_vld", 2, dv[2], 1'b1);

        // asynchronous reset in the middle of a tile
        st[0] = 1'b1;
        kl[0] = CW'(4);
        cyc();
        st[0] = 1'b0;
        mac(0, 8'd6, 8'd7, 1, 1);
        ti[0] = 8'h55;
        tv[0] = 1'b1;
        rst = 1'b1;
        #1;
        chk("arst_busy", 0, busy[0], 1'b0);
        chk("arst_bottom", 0, bot[0], 8'h00);
        chk("arst_dvld", 2, dv[2], 1'b0);
        cyc();
        rst = 1'b0;
        quiet();
        cyc();
        cyc();

        for (int c = 0; c < 300; c++) begin
            for (int l = 0; l < NL; l++) begin
                st[l]  = ($urandom_range(0, 11) == 0);
                kl[l]  = CW'($urandom_range(0, 5));
                ti[l]  = DW'($urandom);
                li[l]  = DW'($urandom);
                tv[l]  = ($urandom_range(0, 3) != 0);
                lv[l]  = ($urandom_range(0, 3) != 0);
                den[l] = ($urandom_range(0, 7) == 0);
            end
            rst = (c == 150);
            cyc();
        end
        rst = 1'b0;
        quiet();
        cyc();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
